// File: rtl/sar_pkg.sv
// Shared types and channel-search helpers for the SAR scan sequencer.
package sar_pkg;

    localparam int unsigned MAX_CH   = 16;
    localparam int unsigned MAX_CH_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StConvert,
        StPost,
        StNext
    } sar_state_e;

    // Result of a channel search: wrap=1 means no enabled channel above the current one.
    typedef struct packed {
        logic                wrap;
        logic [MAX_CH_W-1:0] idx;
    } chan_step_t;

    // Lowest enabled channel in the mask (0 when the mask is empty).
    function automatic logic [MAX_CH_W-1:0] first_chan(input logic [MAX_CH-1:0] mask);
        logic [MAX_CH_W-1:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i]) idx = MAX_CH_W'(i);
        end
        return idx;
    endfunction

    // Next enabled channel strictly above cur; wraps to the lowest enabled one.
    function automatic chan_step_t next_chan(input logic [MAX_CH-1:0]   mask,
                                             input logic [MAX_CH_W-1:0] cur);
        chan_step_t step;
        step.wrap = 1'b1;
        step.idx  = first_chan(mask);
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                step.wrap = 1'b0;
                step.idx  = MAX_CH_W'(i);
            end
        end
        return step;
    endfunction

endpackage

// File: rtl/sar_scan_sequencer_if.sv
// Host and SAR-core signal bundle of the scan sequencer.
// The slave modport is the sequencer; the master modport is the host/SAR environment.
interface sar_scan_sequencer_if #(
    parameter int unsigned DATA = 8,
    parameter int unsigned NCH  = 4,
    parameter int unsigned CH_W = 2
) ();
    logic            Start;
    logic            Continuous;
    logic [NCH-1:0]  ChanEn;
    logic            SarReady;
    logic [DATA-1:0] SarData;
    logic            SarReset;
    logic [CH_W-1:0] MuxSel;
    logic            ResValid;
    logic [CH_W-1:0] ResChan;
    logic [DATA-1:0] ResData;
    logic            ResAck;
    logic            Busy;
    logic            TimeoutErr;

    modport master (
        output Start, Continuous, ChanEn, SarReady, SarData, ResAck,
        input  SarReset, MuxSel, ResValid, ResChan, ResData, Busy, TimeoutErr
    );

    modport slave (
        input  Start, Continuous, ChanEn, SarReady, SarData, ResAck,
        output SarReset, MuxSel, ResValid, ResChan, ResData, Busy, TimeoutErr
    );
endinterface

// File: rtl/sar_result_hold.sv
// One-entry valid/ack holding register for {channel, conversion result}.
module sar_result_hold #(
    parameter int unsigned DATA = 8,
    parameter int unsigned CH_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [CH_W-1:0] wr_chan,
    input  logic [DATA-1:0] wr_data,
    input  logic            ack,
    output logic            ready,
    output logic            valid,
    output logic [CH_W-1:0] chan,
    output logic [DATA-1:0] data
);
    logic            valid_q;
    logic [CH_W-1:0] chan_q;
    logic [DATA-1:0] data_q;

    // A write is accepted when empty or when the held entry is consumed this cycle.
    always_comb ready = !valid_q || ack;

    // Write wins over ack so a simultaneous ack+write keeps valid high with new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            chan_q  <= '0;
            data_q  <= '0;
        end else if (wr && ready) begin
            valid_q <= 1'b1;
            chan_q  <= wr_chan;
            data_q  <= wr_data;
        end else if (ack) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign chan  = chan_q;
    assign data  = data_q;
endmodule

// File: rtl/sar_scan_sequencer.sv
// Scan controller: steps the analog mux over enabled channels, settles, runs one SAR
// conversion per channel and hands results to the host through a one-entry holding register.
module sar_scan_sequencer
    import sar_pkg::*;
#(
    parameter int unsigned DATA    = 8,
    parameter int unsigned NCH     = 4,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 24
) (
    input logic                 Clock,
    input logic                 Reset,
    sar_scan_sequencer_if.slave bus
);
    localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [SETTLE_W-1:0] SettleLast = SETTLE_W'(SETTLE - 1);
    localparam logic [TMO_W-1:0]    TmoLast    = TMO_W'(TIMEOUT - 1);

    sar_state_e          state_q;
    logic                sar_reset_q;
    logic [CH_W-1:0]     mux_sel_q;
    logic [NCH-1:0]      mask_q;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic [DATA-1:0]     cap_data_q;
    logic                tmo_err_q;
    logic                busy_q;

    chan_step_t          step;
    logic [CH_W-1:0]     start_chan;
    logic                hold_ready;
    logic                hold_wr;
    logic                res_valid;
    logic [CH_W-1:0]     res_chan;
    logic [DATA-1:0]     res_data;

    // Channel search on the latched mask, plus the first channel of a freshly sampled mask.
    always_comb begin
        step       = next_chan(MAX_CH'(mask_q), MAX_CH_W'(mux_sel_q));
        start_chan = CH_W'(first_chan(MAX_CH'(bus.ChanEn)));
        hold_wr    = (state_q == StPost) && hold_ready;
    end

    // Scan FSM with registered outputs and inline settle/timeout counters.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= StIdle;
            sar_reset_q  <= 1'b1;
            mux_sel_q    <= '0;
            mask_q       <= '0;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            cap_data_q   <= '0;
            tmo_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.Start && (|bus.ChanEn)) begin
                        mask_q       <= bus.ChanEn;
                        tmo_err_q    <= 1'b0;
                        mux_sel_q    <= start_chan;
                        settle_cnt_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_cnt_q == SettleLast) begin
                        sar_reset_q <= 1'b0;
                        tmo_cnt_q   <= '0;
                        state_q     <= StConvert;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                StConvert: begin
                    // Ready has priority over expiry in the last allowed cycle.
                    if (bus.SarReady) begin
                        cap_data_q  <= bus.SarData;
                        sar_reset_q <= 1'b1;
                        state_q     <= StPost;
                    end else if (tmo_cnt_q == TmoLast) begin
                        tmo_err_q   <= 1'b1;
                        sar_reset_q <= 1'b1;
                        state_q     <= StNext;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                StPost: begin
                    if (hold_wr) state_q <= StNext;
                end
                StNext: begin
                    settle_cnt_q <= '0;
                    if (!step.wrap) begin
                        mux_sel_q <= CH_W'(step.idx);
                        state_q   <= StSettle;
                    end else if (bus.Continuous && (|bus.ChanEn)) begin
                        mask_q    <= bus.ChanEn;
                        mux_sel_q <= start_chan;
                        state_q   <= StSettle;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    sar_result_hold #(
        .DATA (DATA),
        .CH_W (CH_W)
    ) u_hold (
        .clk     (Clock),
        .rst     (Reset),
        .wr      (hold_wr),
        .wr_chan (mux_sel_q),
        .wr_data (cap_data_q),
        .ack     (bus.ResAck),
        .ready   (hold_ready),
        .valid   (res_valid),
        .chan    (res_chan),
        .data    (res_data)
    );

    assign bus.SarReset   = sar_reset_q;
    assign bus.MuxSel     = mux_sel_q;
    assign bus.ResValid   = res_valid;
    assign bus.ResChan    = res_chan;
    assign bus.ResData    = res_data;
    assign bus.Busy       = busy_q;
    assign bus.TimeoutErr = tmo_err_q;
endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Randomized bench for the SAR scan sequencer with a SAR/host environment and a
// scoreboard of expected {channel, data} results derived from the enable mask.
module tb_sar_scan_sequencer;
    localparam int unsigned DATA    = 8;
    localparam int unsigned NCH     = 4;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 24;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [DATA-1:0] d;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sar_scan_sequencer_if #(.DATA(DATA), .NCH(NCH), .CH_W(CH_W)) bus ();

    sar_scan_sequencer #(
        .DATA    (DATA),
        .NCH     (NCH),
        .CH_W    (CH_W),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int             n_checks = 0;
    int             n_fail   = 0;
    res_t           exp_q[$];
    int             ack_mode = 0;   // 0: always ack, 1: random ack, 2: never ack
    logic [NCH-1:0] hang     = '0;  // channels whose SAR never raises Ready
    bit             spurious_en = 1'b0;
    logic [DATA-1:0] data_base = 8'hA0;
    int             n_xfer   = 0;
    logic [NCH-1:0] mux_seen = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // The analog mux presents channel-dependent voltages, so the SAR code tracks the channel.
    function automatic logic [DATA-1:0] data_of(input logic [CH_W-1:0] ch);
        return data_base + DATA'(ch);
    endfunction

    // One pass converts every enabled, responsive channel in ascending order.
    task automatic push_pass(input logic [NCH-1:0] mask, input logic [NCH-1:0] dead);
        res_t r;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            if (mask[ch] && !dead[ch]) begin
                r.ch = CH_W'(ch);
                r.d  = data_of(CH_W'(ch));
                exp_q.push_back(r);
            end
        end
    endtask

    // SAR core, host and timing monitors; inputs change on the falling edge.
    initial begin : env
        int             conv_cnt = 0;
        int             conv_lat = 1;
        int             since_evt = 0;
        bit             armed = 1'b0;
        int             low_run = 0;
        int             last_run = 0;
        bit             stall_pend = 1'b0;
        logic [31:0]    stall_snap = '0;
        logic [CH_W-1:0] prev_mux = '0;
        logic           prev_busy = 1'b0;
        logic           prev_sar = 1'b1;
        logic           prev_terr = 1'b0;
        res_t           e;
        bus.SarReady = 1'b0;
        bus.SarData  = '0;
        bus.ResAck   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || bus.SarReset) begin
                conv_cnt     = 0;
                conv_lat     = $urandom_range(1, DATA + 2);
                bus.SarReady = spurious_en && ($urandom_range(0, 7) == 0);
                bus.SarData  = DATA'($urandom);
            end else begin
                conv_cnt++;
                bus.SarReady = !hang[bus.MuxSel] && (conv_cnt == conv_lat);
                bus.SarData  = bus.SarReady ? data_of(bus.MuxSel) : DATA'($urandom);
            end
            case (ack_mode)
                0:       bus.ResAck = 1'b1;
                1:       bus.ResAck = ($urandom_range(0, 2) != 0);
                default: bus.ResAck = 1'b0;
            endcase
            if (!rst && bus.Busy) mux_seen[bus.MuxSel] = 1'b1;
            if (stall_pend) begin
                check_eq("hold_valid_stable", 32'(bus.ResValid), 32'd1);
                check_eq("hold_entry_stable", 32'({bus.ResChan, bus.ResData}), stall_snap);
            end
            stall_pend = bus.ResValid && !bus.ResAck && !rst;
            stall_snap = 32'({bus.ResChan, bus.ResData});
            if (bus.ResValid && bus.ResAck && !rst) begin
                if (exp_q.size() == 0) begin
                    check_eq("result_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("res_chan", 32'(bus.ResChan), 32'(e.ch));
                    check_eq("res_data", 32'(bus.ResData), 32'(e.d));
                end
                n_xfer++;
            end
            if ((bus.MuxSel != prev_mux) || (bus.Busy && !prev_busy)) begin
                since_evt = 0;
                armed     = 1'b1;
            end
            if (bus.SarReset) begin
                since_evt++;
            end else if (prev_sar && armed) begin
                check_eq("settle_len", 32'(since_evt), 32'(SETTLE));
                armed = 1'b0;
            end
            if (!bus.SarReset) begin
                low_run++;
            end else begin
                if (!prev_sar) last_run = low_run;
                low_run = 0;
            end
            if (bus.TimeoutErr && !prev_terr && !rst)
                check_eq("timeout_latency", 32'(last_run), 32'(TIMEOUT));
            prev_mux  = bus.MuxSel;
            prev_busy = bus.Busy;
            prev_sar  = bus.SarReset;
            prev_terr = bus.TimeoutErr;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_sar_reset"}, 32'(bus.SarReset), 32'd1);
        check_eq({tag, "_mux_sel"}, 32'(bus.MuxSel), 32'd0);
        check_eq({tag, "_res_valid"}, 32'(bus.ResValid), 32'd0);
        check_eq({tag, "_res_chan"}, 32'(bus.ResChan), 32'd0);
        check_eq({tag, "_res_data"}, 32'(bus.ResData), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.Busy), 32'd0);
        check_eq({tag, "_timeout_err"}, 32'(bus.TimeoutErr), 32'd0);
    endtask

    task automatic do_start(input logic [NCH-1:0] mask);
        bus.ChanEn = mask;
        bus.Start  = 1'b1;
        tick();
        bus.Start = 1'b0;
        check_eq("busy_after_start", 32'(bus.Busy), 32'(mask != 0));
        if (mask != 0) check_eq("terr_cleared_by_start", 32'(bus.TimeoutErr), 32'd0);
    endtask

    task automatic wait_done(input logic exp_terr);
        for (int i = 0; i < 3000 && bus.Busy; i++) tick();
        check_eq("busy_falls", 32'(bus.Busy), 32'd0);
        for (int i = 0; i < 200 && bus.ResValid; i++) tick();
        check_eq("results_drained", 32'(exp_q.size()), 32'd0);
        check_eq("timeout_err", 32'(bus.TimeoutErr), 32'(exp_terr));
        check_eq("idle_sar_reset", 32'(bus.SarReset), 32'd1);
    endtask

    initial begin : main
        logic [NCH-1:0] mask;
        logic [NCH-1:0] dead;
        int             base;
        rst            = 1'b1;
        bus.Start      = 1'b0;
        bus.Continuous = 1'b0;
        bus.ChanEn     = '0;
        tick(3);
        check_reset_vals("reset");
        rst = 1'b0;
        tick(2);

        // Single scan over 1011 with immediate ack.
        mux_seen = '0;
        push_pass(4'b1011, '0);
        do_start(4'b1011);
        wait_done(1'b0);
        check_eq("mux_never_ch2", 32'(mux_seen[2]), 32'd0);

        // Host stalls: first result must stay put while the next one waits in POST.
        push_pass(4'b1011, '0);
        ack_mode = 2;
        do_start(4'b1011);
        for (int i = 0; i < 200 && !bus.ResValid; i++) tick();
        tick(40);
        check_eq("stall_res_valid", 32'(bus.ResValid), 32'd1);
        check_eq("stall_res_data", 32'(bus.ResData), 32'(data_of(0)));
        check_eq("stall_res_chan", 32'(bus.ResChan), 32'd0);
        check_eq("stall_sar_reset", 32'(bus.SarReset), 32'd1);
        check_eq("stall_busy", 32'(bus.Busy), 32'd1);
        check_eq("stall_mux_sel", 32'(bus.MuxSel), 32'd1);
        ack_mode = 0;
        tick();
        check_eq("ack_write_valid", 32'(bus.ResValid), 32'd1);
        check_eq("ack_write_data", 32'(bus.ResData), 32'(data_of(1)));
        check_eq("ack_write_chan", 32'(bus.ResChan), 32'd1);
        wait_done(1'b0);

        // Channel 1 never answers: timeout, skip, and a later Start clears the flag.
        hang = 4'b0010;
        push_pass(4'b1011, hang);
        do_start(4'b1011);
        wait_done(1'b1);
        hang = '0;
        push_pass(4'b0001, '0);
        do_start(4'b0001);
        wait_done(1'b0);

        // Continuous mode with a mask change mid-pass, then stop after the following pass.
        base = n_xfer;
        bus.Continuous = 1'b1;
        push_pass(4'b0011, '0);
        push_pass(4'b0100, '0);
        push_pass(4'b0100, '0);
        do_start(4'b0011);
        for (int i = 0; i < 500 && n_xfer < base + 1; i++) tick();
        bus.ChanEn = 4'b0100;
        for (int i = 0; i < 500 && n_xfer < base + 3; i++) tick();
        bus.Continuous = 1'b0;
        wait_done(1'b0);
        check_eq("continuous_count", 32'(n_xfer - base), 32'd4);

        // Reset during CONVERT aborts at once; an empty-mask Start is ignored.
        do_start(4'b0110);
        for (int i = 0; i < 100 && bus.SarReset; i++) tick();
        check_eq("in_convert", 32'(bus.SarReset), 32'd0);
        rst = 1'b1;
        tick();
        check_reset_vals("abort");
        rst = 1'b0;
        exp_q.delete();
        do_start('0);
        tick(5);
        check_eq("empty_start_idle", 32'(bus.Busy), 32'd0);
        check_eq("empty_start_valid", 32'(bus.ResValid), 32'd0);

        // Random scans with spurious Ready pulses, random ack and occasional dead channels.
        spurious_en = 1'b1;
        for (int it = 0; it < 20; it++) begin
            mask      = NCH'($urandom_range(1, (1 << NCH) - 1));
            dead      = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            hang      = dead;
            ack_mode  = int'($urandom_range(0, 1));
            data_base = DATA'($urandom);
            push_pass(mask, dead);
            do_start(mask);
            wait_done(|(mask & dead));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
